// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe: bitwise gate op on WIDTH-bit operands, buffered in a DEPTH-entry valid/ready FIFO.
// Define LOGIC_GATE_PIPE_STATS_EN to add the saturating pop counter (xfer_count / clr_count).
module logic_gate_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out
`ifdef LOGIC_GATE_PIPE_STATS_EN
  ,
  output logic [15:0]      xfer_count,
  input  logic             clr_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd, r_wr;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_res;
  logic             w_push, w_pop;
  always_comb begin
    w_res = op == 3'd0 ? ~a :
            op == 3'd1 ? a :
            op == 3'd2 ? a & b :
            op == 3'd3 ? a | b :
            op == 3'd4 ? a ^ b :
            op == 3'd5 ? ~(a & b) :
            op == 3'd6 ? ~(a | b) : ~(a ^ b);
  end
  assign in_ready  = r_cnt != CW'(DEPTH);
  assign out_valid = r_cnt != '0;
  assign out       = out_valid ? r_mem[r_rd] : '0;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= w_res;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
`ifdef LOGIC_GATE_PIPE_STATS_EN
  logic [15:0] r_xfer;
  assign xfer_count = r_xfer;
  // clear takes priority over a coincident pop; count saturates instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_xfer <= '0;
    else if (clr_count) r_xfer <= '0;
    else if (w_pop && r_xfer != 16'hFFFF) r_xfer <= r_xfer + 16'd1;
  end
`endif
endmodule

// File: tb/tb_logic_gate_pipe.sv
// tb_logic_gate_pipe: directed self-checking bench for logic_gate_pipe (WIDTH=8, DEPTH=2).
module tb_logic_gate_pipe;
  logic       clk = 0, rst = 0, in_valid = 0, out_ready = 0;
  logic [7:0] a = 0, b = 0;
  logic [2:0] op = 0;
  logic       in_ready, out_valid;
  logic [7:0] out;
  int         n_cmp = 0, n_bad = 0;
`ifdef LOGIC_GATE_PIPE_STATS_EN
  logic [15:0] xfer_count;
  logic        clr_count = 0;
`endif
  logic_gate_pipe #(.WIDTH(8), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready), .out(out)
`ifdef LOGIC_GATE_PIPE_STATS_EN
    , .xfer_count(xfer_count), .clr_count(clr_count)
`endif
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    #2 rst = 1;
    #2;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset out_valid got %b want 0", out_valid); end
    n_cmp++; if (out !== 8'h00) begin n_bad++; $display("FAIL reset out got %h want 00", out); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset in_ready got %b want 1", in_ready); end
    @(negedge clk) rst = 0;
    step();
  endtask
  task automatic test_all_ops();
    logic [7:0] exp_v [8] = '{8'h0F, 8'hF0, 8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3};
    a = 8'hF0; b = 8'hCC; op = 0; in_valid = 1; out_ready = 1;
    for (int k = 0; k < 8; k++) begin
      step();
      n_cmp++; if (out_valid !== 1'b1 || out !== exp_v[k]) begin n_bad++; $display("FAIL all_ops op%0d got v=%b %h want v=1 %h", k, out_valid, out, exp_v[k]); end
      if (k < 7) op = 3'(k + 1); else in_valid = 0;
    end
    step();
    n_cmp++; if (out_valid !== 1'b0 || out !== 8'h00) begin n_bad++; $display("FAIL all_ops drain got v=%b %h want v=0 00", out_valid, out); end
  endtask
  task automatic test_fill_full();
    out_ready = 0; in_valid = 1; a = 8'h55; op = 0;
    step();
    n_cmp++; if (in_ready !== 1'b1 || out !== 8'hAA) begin n_bad++; $display("FAIL fill first got rdy=%b %h want rdy=1 AA", in_ready, out); end
    op = 1;
    step();
    n_cmp++; if (in_ready !== 1'b0 || out !== 8'hAA) begin n_bad++; $display("FAIL fill full got rdy=%b %h want rdy=0 AA", in_ready, out); end
    a = 8'h0F; b = 8'hF3; op = 3;
    step();
    n_cmp++; if (in_ready !== 1'b0 || out !== 8'hAA) begin n_bad++; $display("FAIL fill held_off got rdy=%b %h want rdy=0 AA", in_ready, out); end
    out_ready = 1;
    step();
    n_cmp++; if (in_ready !== 1'b1 || out !== 8'h55) begin n_bad++; $display("FAIL fill pop1 got rdy=%b %h want rdy=1 55", in_ready, out); end
    step();
    n_cmp++; if (out_valid !== 1'b1 || out !== 8'hFF) begin n_bad++; $display("FAIL fill third got v=%b %h want v=1 FF", out_valid, out); end
    in_valid = 0;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL fill drain got v=%b want 0", out_valid); end
  endtask
  task automatic test_back_to_back();
    out_ready = 0; in_valid = 1; op = 1; a = 8'd0;
    step();
    n_cmp++; if (out !== 8'd0 || out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b prime got v=%b %h want v=1 00", out_valid, out); end
    out_ready = 1;
    for (int i = 1; i <= 10; i++) begin
      a = 8'(i);
      step();
      n_cmp++; if (out !== 8'(i) || out_valid !== 1'b1 || in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b step%0d got v=%b rdy=%b %h want v=1 rdy=1 %h", i, out_valid, in_ready, out, 8'(i)); end
    end
    in_valid = 0;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b drain got v=%b want 0", out_valid); end
  endtask
  task automatic test_empty();
    in_valid = 0; out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++; if (out_valid !== 1'b0 || out !== 8'h00 || in_ready !== 1'b1) begin n_bad++; $display("FAIL empty cyc%0d got v=%b rdy=%b %h want v=0 rdy=1 00", i, out_valid, in_ready, out); end
    end
    out_ready = 0; in_valid = 1; op = 1; a = 8'h3C;
    step();
    a = 8'hC3;
    step();
    in_valid = 0;
    n_cmp++; if (out !== 8'h3C) begin n_bad++; $display("FAIL empty order got %h want 3C", out); end
    out_ready = 1;
    step();
    n_cmp++; if (out !== 8'hC3) begin n_bad++; $display("FAIL empty second got %h want C3", out); end
    step();
  endtask
  task automatic test_reset_mid();
    out_ready = 0; in_valid = 1; op = 2; a = 8'hF0; b = 8'h3C;
    step();
    op = 7;
    step();
    in_valid = 0;
    n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out !== 8'h30) begin n_bad++; $display("FAIL rstmid pre got v=%b rdy=%b %h want v=1 rdy=0 30", out_valid, in_ready, out); end
    #2 rst = 1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out !== 8'h00 || in_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid async got v=%b rdy=%b %h want v=0 rdy=1 00", out_valid, in_ready, out); end
    @(negedge clk) rst = 0;
    out_ready = 1;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid after got v=%b want 0", out_valid); end
  endtask
`ifdef LOGIC_GATE_PIPE_STATS_EN
  task automatic test_stats();
    #2 rst = 1;
    #1;
    n_cmp++; if (xfer_count !== 16'h0) begin n_bad++; $display("FAIL stats reset got %h want 0000", xfer_count); end
    @(negedge clk) rst = 0;
    step();
    in_valid = 1; op = 1; a = 8'h11; out_ready = 0;
    step();
    out_ready = 1;
    for (int i = 0; i < 70000; i++) step();
    n_cmp++; if (xfer_count !== 16'hFFFF) begin n_bad++; $display("FAIL stats sat got %h want FFFF", xfer_count); end
    clr_count = 1;
    step();
    clr_count = 0;
    n_cmp++; if (xfer_count !== 16'h0) begin n_bad++; $display("FAIL stats clr got %h want 0000", xfer_count); end
    step();
    n_cmp++; if (xfer_count !== 16'h1) begin n_bad++; $display("FAIL stats inc got %h want 0001", xfer_count); end
    in_valid = 0;
    step();
  endtask
`endif
  initial begin
    test_reset();
    test_all_ops();
    test_fill_full();
    test_back_to_back();
    test_empty();
    test_reset_mid();
`ifdef LOGIC_GATE_PIPE_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
